// File: rtl/pcgen_pkg.sv
// pcgen_pkg: shared types and constants for the pc_gen next-PC generator
package pcgen_pkg;
  typedef enum logic [1:0] {BOOT, RUN, HALT} pc_state_e;
  localparam int PC_INC_WORD = 4;
  localparam int PC_INC_HALF = 2;
  localparam int PC_XLEN = 32;
  typedef struct packed {
    logic valid;
    logic [PC_XLEN-1:0] pc;
  } redirect_t;
endpackage

// File: rtl/pc_redirect_buf.sv
// pc_redirect_buf: pending-redirect register; capture loads/overwrites target, clear consumes it
//   ports: clk, reset (sync, active-high), capture/capture_pc, clear, pend_valid/pend_pc out
module pc_redirect_buf #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            capture,
  input  logic [XLEN-1:0] capture_pc,
  input  logic            clear,
  output logic            pend_valid,
  output logic [XLEN-1:0] pend_pc
);
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_valid <= 1'b0;
      pend_pc <= '0;
    end else if (capture) begin
      pend_valid <= 1'b1;
      pend_pc <= capture_pc;
    end else if (clear) begin
      pend_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/pc_gen.sv
// pc_gen: next-PC generator and imem fetch-request source (stall, redirect, trap, halt/resume)
//   config: define PCGEN_COMPRESSED_EN for 16-bit instruction support (inc 2/4, bit0 alignment)
//   ports: clk, reset (sync, active-high), stall_i, redirect_valid_i/redirect_pc_i,
//          trap_valid_i/trap_pc_i, halt_i, resume_i, is_compressed_i, if_ready_i,
//          if_valid_o, pc_o, pc_seq_o (pc_o + inc), misalign_o/misalign_pc_o
module pc_gen
  import pcgen_pkg::*;
#(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            trap_valid_i,
  input  logic [XLEN-1:0] trap_pc_i,
  input  logic            halt_i,
  input  logic            resume_i,
  input  logic            is_compressed_i,
  input  logic            if_ready_i,
  output logic            if_valid_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_seq_o,
  output logic            misalign_o,
  output logic [XLEN-1:0] misalign_pc_o
);
  pc_state_e state;
  logic [XLEN-1:0] inc, pend_pc, pc_next;
  logic mis, live, run, pend_valid, trap_take, redir_ok, capture, take_redir, take_pend, advance, mis_hit;
`ifdef PCGEN_COMPRESSED_EN
  assign inc = is_compressed_i ? XLEN'(PC_INC_HALF) : XLEN'(PC_INC_WORD);
  assign mis = redirect_pc_i[0];
`else
  logic unused_compressed;
  assign unused_compressed = is_compressed_i;
  assign inc = XLEN'(PC_INC_WORD);
  assign mis = |redirect_pc_i[1:0];
`endif
  assign run = state == RUN;
  assign live = run || state == HALT;
  assign if_valid_o = run && !stall_i;
  assign pc_seq_o = pc_o + inc;
  assign trap_take = live && trap_valid_i;
  assign mis_hit = live && !trap_valid_i && redirect_valid_i && mis;
  assign redir_ok = live && !trap_valid_i && redirect_valid_i && !mis;
  // in HALT every good redirect is parked; it takes effect once RUN resumes
  assign capture = redir_ok && (stall_i || !run);
  assign take_redir = redir_ok && run && !stall_i;
  assign take_pend = run && !trap_valid_i && !redirect_valid_i && pend_valid && !stall_i;
  assign advance = run && !trap_valid_i && !redirect_valid_i && !pend_valid && !stall_i && if_ready_i;
  always_comb
    pc_next = trap_take ? trap_pc_i : take_redir ? redirect_pc_i : take_pend ? pend_pc : advance ? pc_seq_o : pc_o;
  pc_redirect_buf #(.XLEN(XLEN)) u_buf (
    .clk(clk),
    .reset(reset),
    .capture(capture),
    .capture_pc(redirect_pc_i),
    .clear(trap_take || take_redir || take_pend),
    .pend_valid(pend_valid),
    .pend_pc(pend_pc)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= BOOT;
      pc_o <= RESET_VEC;
      misalign_o <= 1'b0;
      misalign_pc_o <= '0;
    end else begin
      pc_o <= pc_next;
      misalign_o <= mis_hit;
      if (mis_hit) misalign_pc_o <= redirect_pc_i;
      case (state)
        BOOT: state <= RUN;
        RUN: state <= (halt_i && !trap_valid_i) ? HALT : RUN;
        default: state <= (trap_valid_i || resume_i) ? RUN : HALT;
      endcase
    end
  end
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed self-checking bench for pc_gen
module tb_pc_gen;
  logic clk = 1'b0;
  logic reset, stall_i, redirect_valid_i, trap_valid_i, halt_i, resume_i, is_compressed_i, if_ready_i;
  logic [31:0] redirect_pc_i, trap_pc_i;
  logic if_valid_o, misalign_o;
  logic [31:0] pc_o, pc_seq_o, misalign_pc_o;
  int total = 0;
  int bad = 0;

  pc_gen dut (
    .clk(clk), .reset(reset), .stall_i(stall_i),
    .redirect_valid_i(redirect_valid_i), .redirect_pc_i(redirect_pc_i),
    .trap_valid_i(trap_valid_i), .trap_pc_i(trap_pc_i),
    .halt_i(halt_i), .resume_i(resume_i), .is_compressed_i(is_compressed_i),
    .if_ready_i(if_ready_i), .if_valid_o(if_valid_o), .pc_o(pc_o), .pc_seq_o(pc_seq_o),
    .misalign_o(misalign_o), .misalign_pc_o(misalign_pc_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1; stall_i = 0; redirect_valid_i = 0; redirect_pc_i = 0; trap_valid_i = 0;
    trap_pc_i = 0; halt_i = 0; resume_i = 0; is_compressed_i = 0; if_ready_i = 1;
    step(); step();
    chk("rst_pc", pc_o, 32'h0);
    chk("rst_valid", {31'b0, if_valid_o}, 32'h0);
    chk("rst_mis", {31'b0, misalign_o}, 32'h0);
    chk("rst_mis_pc", misalign_pc_o, 32'h0);
    reset = 0;
    step();
    chk("boot_pc", pc_o, 32'h0);
    chk("run_valid", {31'b0, if_valid_o}, 32'h1);
    step(); chk("seq4", pc_o, 32'h4);
    step(); chk("seq8", pc_o, 32'h8);
    step(); chk("seq12", pc_o, 32'hC);
    step(); chk("seq16", pc_o, 32'h10);
    if_ready_i = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("notready_hold", pc_o, 32'h10);
      chk("notready_valid", {31'b0, if_valid_o}, 32'h1);
    end
    if_ready_i = 1;
    step(); chk("ready_adv", pc_o, 32'h14);
    redirect_valid_i = 1; redirect_pc_i = 32'h20;
    step(); chk("redir_20", pc_o, 32'h20);
    redirect_valid_i = 0; stall_i = 1;
    #1 chk("stall_valid", {31'b0, if_valid_o}, 32'h0);
    redirect_valid_i = 1; redirect_pc_i = 32'h100;
    step(); chk("stall_r1", pc_o, 32'h20);
    redirect_pc_i = 32'h200;
    step(); chk("stall_r2", pc_o, 32'h20);
    redirect_valid_i = 0;
    step(); chk("stall_hold", pc_o, 32'h20);
    stall_i = 0;
    step(); chk("pend_apply", pc_o, 32'h200);
    step(); chk("after_pend", pc_o, 32'h204);
    chk("pc_seq", pc_seq_o, 32'h208);
`ifdef PCGEN_COMPRESSED_EN
    is_compressed_i = 1; redirect_valid_i = 1; redirect_pc_i = 32'h102;
    step(); chk("c_redir", pc_o, 32'h102);
    chk("c_nomis", {31'b0, misalign_o}, 32'h0);
    redirect_valid_i = 0;
    step(); chk("c_adv", pc_o, 32'h104);
    is_compressed_i = 0;
`else
    redirect_valid_i = 1; redirect_pc_i = 32'h102;
    step();
    chk("mis_pulse", {31'b0, misalign_o}, 32'h1);
    chk("mis_pc", misalign_pc_o, 32'h102);
    chk("mis_pc_hold", pc_o, 32'h204);
    redirect_valid_i = 0;
    step();
    chk("mis_clear", {31'b0, misalign_o}, 32'h0);
    chk("mis_no_pend", pc_o, 32'h208);
`endif
    stall_i = 1; redirect_valid_i = 1; redirect_pc_i = 32'h300;
    step();
    trap_valid_i = 1; trap_pc_i = 32'h8000_0000; redirect_pc_i = 32'h40;
    step(); chk("trap_load", pc_o, 32'h8000_0000);
    trap_valid_i = 0; redirect_valid_i = 0; stall_i = 0;
    step(); chk("trap_clr_pend", pc_o, 32'h8000_0004);
    halt_i = 1;
    step(); chk("halt_upd", pc_o, 32'h8000_0008);
    halt_i = 0;
    chk("halt_valid", {31'b0, if_valid_o}, 32'h0);
    step(); chk("halt_hold", pc_o, 32'h8000_0008);
    redirect_valid_i = 1; redirect_pc_i = 32'h500;
    step(); chk("halt_capture", pc_o, 32'h8000_0008);
    redirect_valid_i = 0; trap_valid_i = 1; trap_pc_i = 32'hFFFF_FFFC;
    step(); chk("halt_trap", pc_o, 32'hFFFF_FFFC);
    chk("trap_run_valid", {31'b0, if_valid_o}, 32'h1);
    trap_valid_i = 0;
    step(); chk("wrap", pc_o, 32'h0);
    halt_i = 1;
    step(); chk("halt2", pc_o, 32'h4);
    halt_i = 0; redirect_valid_i = 1; redirect_pc_i = 32'h600;
    step(); chk("halt2_cap", pc_o, 32'h4);
    redirect_valid_i = 0; resume_i = 1;
    step(); chk("resume_pc", pc_o, 32'h4);
    resume_i = 0;
    step(); chk("resume_pend", pc_o, 32'h600);
    chk("resume_seq", pc_seq_o, 32'h604);
    halt_i = 1;
    step();
    reset = 1; halt_i = 0;
    step();
    chk("mid_rst_pc", pc_o, 32'h0);
    chk("mid_rst_valid", {31'b0, if_valid_o}, 32'h0);
    reset = 0;
    step(); step(); chk("post_rst_run", pc_o, 32'h4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
